// File: rtl/floating_point_result_buffer.sv
// Registered output stage behind the floating-point multiplier: a 2-entry skid FIFO
// holding {flags, result}, plus sticky exception status and a saturating op counter.
module floating_point_result_buffer #(
   parameter  int EXPONENT_WIDTH = 8,
   parameter  int MANTISSA_WIDTH = 23,
   parameter  int COUNT_WIDTH    = 16,
   localparam int W              = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_result,
   input  logic                   in_underflow,
   input  logic                   in_overflow,
   input  logic                   in_invalid,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_result,
   output logic [2:0]             out_flags,
   input  logic                   sticky_clear,
   output logic [2:0]             sticky_flags,
   output logic [COUNT_WIDTH-1:0] op_count
);

   localparam int EW = W + 3;

   logic [1:0]             occ_q, occ_d;
   logic [EW-1:0]          head_q, head_d;
   logic [EW-1:0]          tail_q, tail_d;
   logic [2:0]             sticky_q, sticky_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   logic          push;
   logic          pop;
   logic [2:0]    in_flags;
   logic [EW-1:0] in_entry;

   assign in_flags = {in_invalid, in_overflow, in_underflow};
   assign in_entry = {in_flags, in_result};

   // Both handshake signals come straight from the occupancy register, so the
   // consumer's ready never reaches back into the multiplier's combinational path.
   assign in_ready  = (occ_q != 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_result   = head_q[W-1:0];
   assign out_flags    = head_q[EW-1:W];
   assign sticky_flags = sticky_q;
   assign op_count     = count_q;

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      // The head register keeps its last contents when the buffer drains empty.
      unique case (occ_q)
         2'd0: begin
            if (push) begin
               head_d = in_entry;
               occ_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = in_entry;
            end else if (push) begin
               tail_d = in_entry;
               occ_d  = 2'd2;
            end else if (pop) begin
               occ_d  = 2'd0;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d = tail_q;
               occ_d  = 2'd1;
            end
         end
         default: occ_d = 2'd0;
      endcase
   end

   always_comb begin
      sticky_d = sticky_clear ? 3'b000 : sticky_q;
      if (push) begin
         sticky_d = sticky_d | in_flags;
      end
      count_d = count_q;
      if (push && (count_q != {COUNT_WIDTH{1'b1}})) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q    <= 2'd0;
         head_q   <= '0;
         tail_q   <= '0;
         sticky_q <= 3'b000;
         count_q  <= '0;
      end else begin
         occ_q    <= occ_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: doc/floating_point_result_buffer.md
Name: floating_point_result_buffer

Overview:
- Registered output stage placed directly downstream of the combinational floating_point_multiplier.
- Captures the packed product and its three exception flags through a valid/ready handshake into a 2-entry skid FIFO, so a stalled consumer never forces a combinational path back through the multiplier.
- Keeps IEEE-style sticky exception status and a saturating count of accepted operations for software readout.

Parameters:
- EXPONENT_WIDTH, 8, exponent field width; must match the upstream multiplier.
- MANTISSA_WIDTH, 23, stored mantissa width; must match the upstream multiplier.
- COUNT_WIDTH, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  buffer can accept a result this cycle.
- in_result  input  W  packed {sign, exponent, mantissa} from the multiplier, where W = EXPONENT_WIDTH+MANTISSA_WIDTH+1.
- in_underflow  input  1  multiplier underflow flag.
- in_overflow  input  1  multiplier overflow flag.
- in_invalid  input  1  multiplier invalid-operation flag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  W  head entry result.
- out_flags  output  3  head entry flags, ordered {invalid, overflow, underflow}.
- sticky_clear  input  1  synchronous clear of sticky_flags.
- sticky_flags  output  3  OR of all accepted flags since the last clear or reset, same ordering as out_flags.
- op_count  output  COUNT_WIDTH  number of accepted inputs, saturating.

Behaviour:
- Storage: 2 entries of W+3 bits each; occupancy register holds 0, 1 or 2.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_result and flags are don't-care while in_valid=0.
- in_ready = (occupancy != 2). It depends only on registered state, never on out_ready.
- out_valid = (occupancy != 0). out_result and out_flags always show the head entry.
  - When empty, they hold their last value; after reset that value is 0.
- Latency: an accepted input is presented at the output in the next cycle. There is no same-cycle bypass.
- Ordering is strict FIFO.
- Occupancy transitions:
  - 0: push → 1.
  - 1: push only → 2; pop only → 0; push and pop together → stays 1, new entry becomes head next cycle.
  - 2: pop → 1, second entry becomes head. A push cannot occur because in_ready=0.
- Head and second entry contents never change while they are stalled (out_valid=1, out_ready=0).
- Sticky flags:
  - On every push, sticky_flags |= {in_invalid, in_overflow, in_underflow}.
  - sticky_clear zeroes them.
  - If sticky_clear and a push carrying flags occur in the same cycle, the result equals that push's flags (set wins over clear).
- op_count:
  - Increments by 1 on each push.
  - Saturates at all ones; no wrap to 0.
  - Unaffected by sticky_clear.
- Reset (rst=1 at clk edge), including mid-transfer:
  - Occupancy=0, out_valid=0, in_ready=1.
  - out_result=0, out_flags=0, sticky_flags=0, op_count=0.
  - Stored entries are discarded, and any push or pop in that cycle is ignored.
- Values are passed through bit-exact; no rounding, canonicalisation or NaN rewriting.

Test Plan:
- Single transfer: push 0x40C00000 (6.0), flags 000, with out_ready=1 → next cycle out_valid=1 and out_result=0x40C00000; the cycle after that out_valid=0; op_count=1.
- Backpressure: out_ready=0, push 0x40400000 then 0x40C00000 → in_ready=0 after the second push. Raise out_ready → outputs appear in order, in_ready=1 after the first pop, and both entries remain stable while stalled.
- Simultaneous push/pop at occupancy 1: occupancy stays 1, the new entry appears next cycle, and no entry is lost or duplicated across 100 random valid/ready patterns against a reference queue.
- Sticky flags:
  - Push 0xFFC00000 with invalid=1, then 0x7F800000 with overflow=1 → sticky_flags=110.
  - Assert sticky_clear alone → 000.
  - Assert sticky_clear together with a push carrying underflow=1 → 001.
- Saturation: COUNT_WIDTH=4, perform 20 pushes → op_count=15 and holds at 15.
- Reset mid-operation: occupancy 2 and sticky_flags=100, assert rst for one cycle → out_valid=0, in_ready=1, sticky_flags=000, op_count=0, and no stale entry is ever output afterwards.
